maq_bcd: RTL and testbench

MAQ_BCD -- requirements
Module: maq_bcd

---
 rtl/maq_bcd.sv | 86 ++++++++
 tb/tb_maq_bcd.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maq_bcd.sv
// Two-digit BCD modulo counter (0..MODULO-1) with up/down counting, validated load,
// registered wrap/load-error pulses and a combinational terminal count for cascading.
module maq_bcd #(
  parameter int MODULO = 60,
  parameter int MSD_W  = 3
) (
  input  logic             maqb_clock,
  input  logic             maqb_reset,
  input  logic             maqb_enable,
  input  logic             maqb_down,
  input  logic             maqb_load,
  input  logic [3:0]       maqb_load_lsd,
  input  logic [MSD_W-1:0] maqb_load_msd,
  output logic [3:0]       maqb_lsd,
  output logic [MSD_W-1:0] maqb_msd,
  output logic             maqb_carry,
  output logic             maqb_borrow,
  output logic             maqb_load_err,
  output logic             maqb_tc
);

  localparam logic [3:0]       TOP_LSD = 4'((MODULO - 1) % 10);
  localparam logic [MSD_W-1:0] TOP_MSD = MSD_W'((MODULO - 1) / 10);
  localparam logic [7:0]       TOP_VAL = 8'(MODULO - 1);

  logic       at_top;
  logic       at_zero;
  logic [7:0] load_val;
  logic       load_ok;

  assign at_top   = (maqb_lsd == TOP_LSD) && (maqb_msd == TOP_MSD);
  assign at_zero  = (maqb_lsd == 4'd0) && (maqb_msd == '0);
  assign maqb_tc  = maqb_down ? at_zero : at_top;

  // Load value in binary so the range check covers both digits at once.
  assign load_val = 8'(maqb_load_msd) * 8'd10 + 8'(maqb_load_lsd);
  assign load_ok  = (maqb_load_lsd <= 4'd9) && (load_val <= TOP_VAL);

  always_ff @(posedge maqb_clock) begin
    if (!maqb_reset) begin
      maqb_lsd      <= 4'd0;
      maqb_msd      <= '0;
      maqb_carry    <= 1'b0;
      maqb_borrow   <= 1'b0;
      maqb_load_err <= 1'b0;
    end else begin
      maqb_carry    <= 1'b0;
      maqb_borrow   <= 1'b0;
      maqb_load_err <= 1'b0;
      if (maqb_load) begin
        // A rejected load still consumes the cycle, so any tick is dropped.
        if (load_ok) begin
          maqb_lsd <= maqb_load_lsd;
          maqb_msd <= maqb_load_msd;
        end else begin
          maqb_load_err <= 1'b1;
        end
      end else if (maqb_enable) begin
        if (!maqb_down) begin
          if (at_top) begin
            maqb_lsd   <= 4'd0;
            maqb_msd   <= '0;
            maqb_carry <= 1'b1;
          end else if (maqb_lsd == 4'd9) begin
            maqb_lsd <= 4'd0;
            maqb_msd <= maqb_msd + MSD_W'(1);
          end else begin
            maqb_lsd <= maqb_lsd + 4'd1;
          end
        end else begin
          if (at_zero) begin
            maqb_lsd    <= TOP_LSD;
            maqb_msd    <= TOP_MSD;
            maqb_borrow <= 1'b1;
          end else if (maqb_lsd == 4'd0) begin
            maqb_lsd <= 4'd9;
            maqb_msd <= maqb_msd - MSD_W'(1);
          end else begin
            maqb_lsd <= maqb_lsd - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maq_bcd.sv
// Scoreboard bench for maq_bcd: three instances (MODULO 60, 24, 100) share one
// stimulus stream and are checked against an arithmetic model of the counter value.
module tb_maq_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_lsd = 4'd0;
  logic [3:0] load_msd = 4'd0;

  logic [3:0] lsd60, lsd24, lsd100;
  logic [2:0] msd60;
  logic [1:0] msd24;
  logic [3:0] msd100;
  logic [2:0] carry, borrow, load_err, tc;

  always #5 clk = ~clk;

  maq_bcd #(.MODULO(60), .MSD_W(3)) dut60 (
    .maqb_clock(clk), .maqb_reset(reset), .maqb_enable(enable), .maqb_down(down),
    .maqb_load(load), .maqb_load_lsd(load_lsd), .maqb_load_msd(load_msd[2:0]),
    .maqb_lsd(lsd60), .maqb_msd(msd60), .maqb_carry(carry[0]), .maqb_borrow(borrow[0]),
    .maqb_load_err(load_err[0]), .maqb_tc(tc[0]));

  maq_bcd #(.MODULO(24), .MSD_W(2)) dut24 (
    .maqb_clock(clk), .maqb_reset(reset), .maqb_enable(enable), .maqb_down(down),
    .maqb_load(load), .maqb_load_lsd(load_lsd), .maqb_load_msd(load_msd[1:0]),
    .maqb_lsd(lsd24), .maqb_msd(msd24), .maqb_carry(carry[1]), .maqb_borrow(borrow[1]),
    .maqb_load_err(load_err[1]), .maqb_tc(tc[1]));

  maq_bcd #(.MODULO(100), .MSD_W(4)) dut100 (
    .maqb_clock(clk), .maqb_reset(reset), .maqb_enable(enable), .maqb_down(down),
    .maqb_load(load), .maqb_load_lsd(load_lsd), .maqb_load_msd(load_msd),
    .maqb_lsd(lsd100), .maqb_msd(msd100), .maqb_carry(carry[2]), .maqb_borrow(borrow[2]),
    .maqb_load_err(load_err[2]), .maqb_tc(tc[2]));

  typedef struct packed {
    logic [6:0] v;
    logic       c;
    logic       b;
    logic       e;
  } step_t;

  typedef struct packed {
    logic [2:0][6:0] v;
    logic [2:0]      c;
    logic [2:0]      b;
    logic [2:0]      e;
  } entry_t;

  entry_t     sbq[$];
  logic [2:0] tcq[$];
  int         cur[3] = '{0, 0, 0};
  int         checks = 0;
  int         errors = 0;

  function automatic int mod_of(int i);
    case (i)
      0: return 60;
      1: return 24;
      default: return 100;
    endcase
  endfunction

  function automatic int msdw_of(int i);
    case (i)
      0: return 3;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic string name_of(int i);
    case (i)
      0: return "m60";
      1: return "m24";
      default: return "m100";
    endcase
  endfunction

  function automatic int dut_lsd(int i);
    case (i)
      0: return int'(lsd60);
      1: return int'(lsd24);
      default: return int'(lsd100);
    endcase
  endfunction

  function automatic int dut_msd(int i);
    case (i)
      0: return int'(msd60);
      1: return int'(msd24);
      default: return int'(msd100);
    endcase
  endfunction

  // Reference: the count is a plain integer in 0..modulo-1; digits are derived from it.
  function automatic step_t model(int modulo, int mw, int v, bit rst_n, bit en, bit dn,
                                  bit ld, int ll, int lm);
    step_t s;
    int    m;
    s = '0;
    s.v = 7'(v);
    if (!rst_n) begin
      s.v = 7'd0;
    end else if (ld) begin
      m = lm % (1 << mw);
      if (ll <= 9 && 10 * m + ll <= modulo - 1) s.v = 7'(10 * m + ll);
      else s.e = 1'b1;
    end else if (en) begin
      if (!dn) begin
        if (v == modulo - 1) begin
          s.v = 7'd0;
          s.c = 1'b1;
        end else s.v = 7'(v + 1);
      end else begin
        if (v == 0) begin
          s.v = 7'(modulo - 1);
          s.b = 1'b1;
        end else s.v = 7'(v - 1);
      end
    end
    return s;
  endfunction

  task automatic apply_stimulus(bit rst_n, bit en, bit dn, bit ld, int ll, int lm);
    entry_t     ent;
    logic [2:0] tce;
    step_t      s;
    @(posedge clk);
    #2;
    reset    = rst_n;
    enable   = en;
    down     = dn;
    load     = ld;
    load_lsd = 4'(ll);
    load_msd = 4'(lm);
    ent = '0;
    for (int i = 0; i < 3; i++) begin
      tce[i] = dn ? (cur[i] == 0) : (cur[i] == mod_of(i) - 1);
      s = model(mod_of(i), msdw_of(i), cur[i], rst_n, en, dn, ld, ll, lm);
      ent.v[i] = s.v;
      ent.c[i] = s.c;
      ent.b[i] = s.b;
      ent.e[i] = s.e;
      cur[i]   = int'(s.v);
    end
    sbq.push_back(ent);
    tcq.push_back(tce);
  endtask

  task automatic check_output(string what, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", what, actual, expected, $time);
    end
  endtask

  // Registered outputs are checked just after the edge that produced them.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          check_output({name_of(i), ".lsd"}, dut_lsd(i), int'(e.v[i]) % 10);
          check_output({name_of(i), ".msd"}, dut_msd(i), int'(e.v[i]) / 10);
          check_output({name_of(i), ".carry"}, int'(carry[i]), int'(e.c[i]));
          check_output({name_of(i), ".borrow"}, int'(borrow[i]), int'(e.b[i]));
          check_output({name_of(i), ".load_err"}, int'(load_err[i]), int'(e.e[i]));
        end
      end
    end
  end

  // Terminal count is combinational on the current value and the applied direction.
  initial begin
    logic [2:0] t;
    forever begin
      @(negedge clk);
      if (tcq.size() > 0) begin
        t = tcq.pop_front();
        for (int i = 0; i < 3; i++)
          check_output({name_of(i), ".tc"}, int'(tc[i]), int'(t[i]));
      end
    end
  end

  initial begin
    int r;
    int guard;
    @(posedge clk);
    apply_stimulus(0, 1, 0, 1, 3, 3);
    // Load 57, step through 58, 59, the carry at 00, then 01.
    apply_stimulus(1, 0, 0, 1, 7, 5);
    repeat (4) apply_stimulus(1, 1, 0, 0, 0, 0);
    // Borrow from 00, with a hold cycle at 00 to see tc without enable.
    apply_stimulus(1, 0, 0, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0);
    repeat (2) apply_stimulus(1, 1, 1, 0, 0, 0);
    // Rejected loads leave the value alone even with enable high.
    apply_stimulus(1, 0, 0, 1, 2, 1);
    apply_stimulus(1, 1, 0, 1, 2, 7);
    apply_stimulus(1, 1, 1, 1, 10, 9);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    // 22 up through 23 and the wrap of the 24 counter.
    apply_stimulus(1, 0, 0, 1, 2, 2);
    repeat (3) apply_stimulus(1, 1, 0, 0, 0, 0);
    // Reset beats load and enable at 59.
    apply_stimulus(1, 0, 0, 1, 9, 5);
    apply_stimulus(0, 1, 0, 1, 9, 5);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    // 99 with hold cycles between ticks.
    apply_stimulus(1, 0, 0, 1, 9, 9);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    repeat (2) apply_stimulus(1, 0, 1, 0, 0, 0);
    apply_stimulus(1, 1, 1, 0, 0, 0);
    // Direction flips on consecutive ticks.
    repeat (3) apply_stimulus(1, 1, 0, 0, 0, 0);
    repeat (3) apply_stimulus(1, 1, 1, 0, 0, 0);
    repeat (400) begin
      r = $urandom_range(0, 99);
      apply_stimulus(r >= 3, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                     r >= 3 && r < 15, $urandom_range(0, 11), $urandom_range(0, 9));
    end
    apply_stimulus(1, 0, 0, 0, 0, 0);
    guard = 0;
    while ((sbq.size() > 0 || tcq.size() > 0) && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sbq.size() > 0 || tcq.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries expected 0", sbq.size() + tcq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
